// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues reads at the current PC, steps the PC register, and queues
// returned instructions tagged with their PC for decode. Redirect flushes.
module instr_fetch_queue #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_ld,
    output logic [ADDR_W-1:0]  pc_next,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  tag_pc_q, tag_pc_d;
    logic [INSTR_W-1:0] entry_instr_q [DEPTH];
    logic [INSTR_W-1:0] entry_instr_d [DEPTH];
    logic [ADDR_W-1:0]  entry_pc_q [DEPTH];
    logic [ADDR_W-1:0]  entry_pc_d [DEPTH];

    logic               pop;
    logic               push;
    logic               issue;
    logic [CNT_W:0]     credit_used;

    // Credits count both stored entries and the response still on its way back,
    // which is what makes overflow impossible without a skid buffer.
    always_comb begin
        instr_valid = ~RST & (count_q != '0);
        pop         = instr_valid & instr_ready & ~redirect;
        push        = ~RST & ~redirect & inflight_q;
        credit_used = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
        issue       = ~RST & ~redirect & (credit_used < (CNT_W + 1)'(DEPTH));
    end

    always_comb begin
        imem_en   = issue;
        imem_addr = pc_in;
        pc_ld     = ~RST & (issue | redirect);
        pc_next   = redirect ? redirect_addr : pc_in + ADDR_W'(1);
        instr_out = entry_instr_q[rd_ptr_q];
        instr_pc  = entry_pc_q[rd_ptr_q];
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = issue;
        tag_pc_d   = issue ? pc_in : tag_pc_q;
        if (RST || redirect) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            inflight_d = 1'b0;
        end else begin
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        rd_ptr_q   <= rd_ptr_d;
        wr_ptr_q   <= wr_ptr_d;
        count_q    <= count_d;
        inflight_q <= inflight_d;
        tag_pc_q   <= tag_pc_d;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_comb begin
                entry_instr_d[gi] = entry_instr_q[gi];
                entry_pc_d[gi]    = entry_pc_q[gi];
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_instr_d[gi] = imem_rdata;
                    entry_pc_d[gi]    = tag_pc_q;
                end
            end

            always_ff @(posedge clk) begin
                entry_instr_q[gi] <= entry_instr_d[gi];
                entry_pc_q[gi]    <= entry_pc_d[gi];
            end
        end
    endgenerate

    a_no_overflow: assert property (@(posedge clk) disable iff (RST)
        !(push && !pop && count_q == FULL_CNT));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a behavioural PC register and a
// one-cycle-latency instruction memory whose data is 0xC0DE0000 | address.
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        RST;
    logic [9:0]  pc_in;
    logic        pc_ld;
    logic [9:0]  pc_next;
    logic        redirect;
    logic [9:0]  redirect_addr;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_queue #(.ADDR_W(10), .INSTR_W(32), .DEPTH(2)) dut (
        .clk(clk), .RST(RST), .pc_in(pc_in), .pc_ld(pc_ld), .pc_next(pc_next),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    // PC register and instruction memory environment
    initial pc_in = '0;
    always @(posedge clk) begin
        if (RST) pc_in <= '0;
        else if (pc_ld) pc_in <= pc_next;
    end
    initial imem_rdata = '0;
    always @(posedge clk) if (imem_en) imem_rdata <= 32'hC0DE_0000 | {22'd0, imem_addr};

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       redir;
        logic [9:0] raddr;
        logic       e_valid;
        logic [9:0] e_pc;
        logic       e_en;
        logic       e_ld;
        logic [9:0] e_pcin;
    } vec_t;

    vec_t vecs[29];
    int   cyc_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cyc %0d %s: got %h expected %h", cyc_no, name, act, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic rdy, input logic redir, input logic [9:0] raddr,
                       input logic ev, input logic [9:0] epc, input logic een, input logic eld,
                       input logic [9:0] epcin);
        logic [9:0] exp_next;
        RST = rst;
        instr_ready = rdy;
        redirect = redir;
        redirect_addr = raddr;
        #2;
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, ev});
        chk("imem_en", {31'd0, imem_en}, {31'd0, een});
        chk("pc_ld", {31'd0, pc_ld}, {31'd0, eld});
        chk("pc_in", {22'd0, pc_in}, {22'd0, epcin});
        if (een) chk("imem_addr", {22'd0, imem_addr}, {22'd0, epcin});
        if (ev) begin
            chk("instr_pc", {22'd0, instr_pc}, {22'd0, epc});
            chk("instr_out", instr_out, 32'hC0DE_0000 | {22'd0, epc});
        end
        if (eld) begin
            exp_next = redir ? raddr : epcin + 10'd1;
            chk("pc_next", {22'd0, pc_next}, {22'd0, exp_next});
        end
        $display("cyc %0d rst=%0b rdy=%0b redir=%0b valid=%0b pc=%h en=%0b ld=%0b pc_in=%h",
                 cyc_no, rst, rdy, redir, instr_valid, instr_pc, imem_en, pc_ld, pc_in);
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    function automatic vec_t v(input logic rst, input logic rdy, input logic redir,
                               input logic [9:0] raddr, input logic ev, input logic [9:0] epc,
                               input logic een, input logic eld, input logic [9:0] epcin);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.redir = redir; r.raddr = raddr;
        r.e_valid = ev; r.e_pc = epc; r.e_en = een; r.e_ld = eld; r.e_pcin = epcin;
        return r;
    endfunction

    initial begin
        // Reset then streaming, ready drop with full queue, reset into a
        // stalled start, then redirect near the top of the address space.
        //          rst rdy rdr raddr   val pc      en ld pc_in
        vecs[0]  = v(1, 1, 0, 10'h0,   0, 10'h0,   0, 0, 10'h0);
        vecs[1]  = v(1, 1, 0, 10'h0,   0, 10'h0,   0, 0, 10'h0);
        vecs[2]  = v(0, 1, 0, 10'h0,   0, 10'h0,   1, 1, 10'h0);
        vecs[3]  = v(0, 1, 0, 10'h0,   0, 10'h0,   1, 1, 10'h1);
        vecs[4]  = v(0, 1, 0, 10'h0,   1, 10'h0,   1, 1, 10'h2);
        vecs[5]  = v(0, 1, 0, 10'h0,   1, 10'h1,   1, 1, 10'h3);
        vecs[6]  = v(0, 0, 0, 10'h0,   1, 10'h2,   0, 0, 10'h4);
        vecs[7]  = v(0, 0, 0, 10'h0,   1, 10'h2,   0, 0, 10'h4);
        vecs[8]  = v(0, 0, 0, 10'h0,   1, 10'h2,   0, 0, 10'h4);
        vecs[9]  = v(0, 1, 0, 10'h0,   1, 10'h2,   1, 1, 10'h4);
        vecs[10] = v(0, 1, 0, 10'h0,   1, 10'h3,   1, 1, 10'h5);
        vecs[11] = v(0, 1, 0, 10'h0,   1, 10'h4,   1, 1, 10'h6);
        vecs[12] = v(1, 0, 0, 10'h0,   0, 10'h0,   0, 0, 10'h7);
        vecs[13] = v(1, 0, 0, 10'h0,   0, 10'h0,   0, 0, 10'h0);
        vecs[14] = v(0, 0, 0, 10'h0,   0, 10'h0,   1, 1, 10'h0);
        vecs[15] = v(0, 0, 0, 10'h0,   0, 10'h0,   1, 1, 10'h1);
        vecs[16] = v(0, 0, 0, 10'h0,   1, 10'h0,   0, 0, 10'h2);
        vecs[17] = v(0, 0, 0, 10'h0,   1, 10'h0,   0, 0, 10'h2);
        vecs[18] = v(0, 0, 0, 10'h0,   1, 10'h0,   0, 0, 10'h2);
        vecs[19] = v(0, 1, 0, 10'h0,   1, 10'h0,   1, 1, 10'h2);
        vecs[20] = v(0, 1, 0, 10'h0,   1, 10'h1,   1, 1, 10'h3);
        vecs[21] = v(0, 1, 0, 10'h0,   1, 10'h2,   1, 1, 10'h4);
        vecs[22] = v(0, 1, 1, 10'h3FE, 1, 10'h3,   0, 1, 10'h5);
        vecs[23] = v(0, 1, 0, 10'h0,   0, 10'h0,   1, 1, 10'h3FE);
        vecs[24] = v(0, 1, 0, 10'h0,   0, 10'h0,   1, 1, 10'h3FF);
        vecs[25] = v(0, 1, 0, 10'h0,   1, 10'h3FE, 1, 1, 10'h000);
        vecs[26] = v(0, 1, 0, 10'h0,   1, 10'h3FF, 1, 1, 10'h001);
        vecs[27] = v(0, 1, 0, 10'h0,   1, 10'h000, 1, 1, 10'h002);
        vecs[28] = v(0, 1, 0, 10'h0,   1, 10'h001, 1, 1, 10'h003);

        RST = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_addr = '0;
        #1;
        for (int i = 0; i < 29; i++)
            cyc(vecs[i].rst, vecs[i].rdy, vecs[i].redir, vecs[i].raddr,
                vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_en, vecs[i].e_ld, vecs[i].e_pcin);

        // Fill the queue, redirect to 0x200; old entries 2/3 must never show.
        cyc(0, 0, 0, 10'h0,   1, 10'h002, 0, 0, 10'h004);
        cyc(0, 0, 0, 10'h0,   1, 10'h002, 0, 0, 10'h004);
        cyc(0, 0, 1, 10'h200, 1, 10'h002, 0, 1, 10'h004);
        cyc(0, 0, 0, 10'h0,   0, 10'h000, 1, 1, 10'h200);
        cyc(0, 0, 0, 10'h0,   0, 10'h000, 1, 1, 10'h201);
        cyc(0, 0, 0, 10'h0,   1, 10'h200, 0, 0, 10'h202);
        cyc(0, 0, 0, 10'h0,   1, 10'h200, 0, 0, 10'h202);
        cyc(0, 1, 0, 10'h0,   1, 10'h200, 1, 1, 10'h202);
        cyc(0, 1, 0, 10'h0,   1, 10'h201, 1, 1, 10'h203);

        // Redirect while valid&ready and a response for 0x203 is arriving.
        cyc(0, 1, 1, 10'h155, 1, 10'h202, 0, 1, 10'h204);
        cyc(0, 1, 0, 10'h0,   0, 10'h000, 1, 1, 10'h155);
        cyc(0, 1, 0, 10'h0,   0, 10'h000, 1, 1, 10'h156);
        cyc(0, 1, 0, 10'h0,   1, 10'h155, 1, 1, 10'h157);

        // Reset with one entry queued and one in flight; restart from 0.
        cyc(1, 0, 0, 10'h0,   0, 10'h000, 0, 0, 10'h158);
        cyc(1, 0, 0, 10'h0,   0, 10'h000, 0, 0, 10'h000);
        cyc(0, 1, 0, 10'h0,   0, 10'h000, 1, 1, 10'h000);
        cyc(0, 1, 0, 10'h0,   0, 10'h000, 1, 1, 10'h001);
        cyc(0, 1, 0, 10'h0,   1, 10'h000, 1, 1, 10'h002);
        cyc(0, 1, 0, 10'h0,   1, 10'h001, 1, 1, 10'h003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
